// File: rtl/usb_rx_phy_param.sv
// usb_rx_phy_param
//   USB full-speed receive front end with a configurable oversampling ratio.
//   Synchronises the raw D+/D- pair, recovers bit timing from line edges,
//   NRZI-decodes, removes stuffed bits, checks SYNC, assembles bytes and
//   reports packet framing and errors.
//
// Parameters
//   CLKS_PER_BIT  clocks per USB bit time (>= 4, even)
//   MAX_BYTES     largest legal number of data bytes after SYNC
//   STUFF_EN      1: drop stuffed zeros and flag stuff errors; 0: all bits are data
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   dp_i, dm_i  asynchronous USB line pair
//   byte_data   assembled byte (LSB received first), valid with byte_valid
//   byte_valid  one-cycle strobe per delivered byte
//   sop         one-cycle pulse after a valid SYNC
//   eop         one-cycle pulse after a clean end of packet
//   rcving      high while a packet (or its error recovery) is in progress
//   r_error     sticky error flag, cleared at the next packet start
//   byte_count  data bytes delivered in the current / last packet
//
// Handshake: byte_valid, sop and eop are pure strobes with no back-pressure;
// the consumer must take byte_data in the single cycle byte_valid is high.
module usb_rx_phy_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64,
    parameter bit STUFF_EN     = 1'b1,
    localparam int CW          = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dp_i,
    input  logic          dm_i,
    output logic [7:0]    byte_data,
    output logic          byte_valid,
    output logic          sop,
    output logic          eop,
    output logic          rcving,
    output logic          r_error,
    output logic [CW-1:0] byte_count
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BYTES);

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [1:0] SYM_SE1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and bit timing
    // ------------------------------------------------------------------
    logic          dp_meta, dp_sync, dm_meta, dm_sync;
    logic [1:0]    sym_d;
    logic [PW-1:0] phase;
    logic [1:0]    sym;
    logic          sym_change;
    logic          sample;

    assign sym        = {dp_sync, dm_sync};
    assign sym_change = (sym != sym_d);
    // Never sample on the cycle a new symbol first appears: the counter is
    // about to realign to that edge and will sample it mid-bit instead.
    assign sample     = !sym_change && (phase == PH_SAMPLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchroniser resets to J so an idle line produces no false edge.
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
            sym_d   <= SYM_J;
            phase   <= '0;
        end else begin
            dp_meta <= dp_i;
            dp_sync <= dp_meta;
            dm_meta <= dm_i;
            dm_sync <= dm_meta;
            sym_d   <= sym;
            if (sym_change || phase == PH_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [1:0]    prev_samp, prev_samp_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [2:0]    ones, ones_n;
    logic          se0_seen, se0_seen_n;
    logic [7:0]    byte_data_n;
    logic          byte_valid_n, sop_n, eop_n, rcving_n, r_error_n;
    logic [CW-1:0] byte_count_n;

    logic          decoded;
    logic [7:0]    shifted;
    logic          is_jk;
    logic [2:0]    ones_inc;

    assign decoded  = (sym == prev_samp);
    assign shifted  = {decoded, shreg[7:1]};
    assign is_jk    = (sym == SYM_J) || (sym == SYM_K);
    assign ones_inc = decoded ? ((ones == 3'd7) ? ones : ones + 3'd1) : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prev_samp  <= SYM_J;
            shreg      <= '0;
            bit_idx    <= '0;
            ones       <= '0;
            se0_seen   <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            rcving     <= 1'b0;
            r_error    <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_n;
            prev_samp  <= prev_samp_n;
            shreg      <= shreg_n;
            bit_idx    <= bit_idx_n;
            ones       <= ones_n;
            se0_seen   <= se0_seen_n;
            byte_data  <= byte_data_n;
            byte_valid <= byte_valid_n;
            sop        <= sop_n;
            eop        <= eop_n;
            rcving     <= rcving_n;
            r_error    <= r_error_n;
            byte_count <= byte_count_n;
        end
    end

    always_comb begin
        state_n      = state;
        prev_samp_n  = prev_samp;
        shreg_n      = shreg;
        bit_idx_n    = bit_idx;
        ones_n       = ones;
        se0_seen_n   = se0_seen;
        byte_data_n  = byte_data;
        byte_valid_n = 1'b0;
        sop_n        = 1'b0;
        eop_n        = 1'b0;
        rcving_n     = rcving;
        r_error_n    = r_error;
        byte_count_n = byte_count;

        case (state)
            ST_IDLE: begin
                prev_samp_n = SYM_J;
                ones_n      = '0;
                bit_idx_n   = '0;
                if (sym_d == SYM_J && sym == SYM_K) begin
                    state_n      = ST_SYNC;
                    rcving_n     = 1'b1;
                    r_error_n    = 1'b0;
                    byte_count_n = '0;
                end
            end

            ST_SYNC: begin
                if (sample) begin
                    if (!is_jk) begin
                        state_n = ST_ERR;
                    end else begin
                        prev_samp_n = sym;
                        ones_n      = ones_inc;
                        shreg_n     = shifted;
                        bit_idx_n   = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (shifted == 8'h80) begin
                                state_n = ST_DATA;
                                sop_n   = 1'b1;
                            end else begin
                                state_n = ST_ERR;
                            end
                        end
                    end
                end
            end

            ST_DATA: begin
                if (sample) begin
                    if (sym == SYM_SE0) begin
                        state_n = (bit_idx == 3'd0) ? ST_EOP : ST_ERR;
                    end else if (sym == SYM_SE1) begin
                        state_n = ST_ERR;
                    end else begin
                        prev_samp_n = sym;
                        if (STUFF_EN && ones == 3'd6) begin
                            // Bit after six ones: a zero is the stuff bit and
                            // is dropped; a one breaks the stuffing rule.
                            if (decoded) begin
                                state_n = ST_ERR;
                            end else begin
                                ones_n = '0;
                            end
                        end else begin
                            ones_n    = ones_inc;
                            shreg_n   = shifted;
                            bit_idx_n = bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                if (byte_count == CNT_MAX) begin
                                    state_n = ST_ERR;
                                end else begin
                                    byte_valid_n = 1'b1;
                                    byte_data_n  = shifted;
                                    byte_count_n = byte_count + 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            ST_EOP: begin
                if (sample) begin
                    if (sym == SYM_J) begin
                        state_n  = ST_IDLE;
                        eop_n    = 1'b1;
                        rcving_n = 1'b0;
                    end else if (sym != SYM_SE0) begin
                        state_n = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                r_error_n = 1'b1;
                rcving_n  = 1'b1;
                if (sample) begin
                    if (sym == SYM_SE0) begin
                        se0_seen_n = 1'b1;
                    end else if (sym == SYM_J) begin
                        if (se0_seen) begin
                            state_n    = ST_IDLE;
                            rcving_n   = 1'b0;
                            se0_seen_n = 1'b0;
                        end
                    end else begin
                        se0_seen_n = 1'b0;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Entering ERR: flag immediately; an SE0 that caused the error
        // (early EOP) already counts toward the SE0-then-J exit.
        if (state_n == ST_ERR && state != ST_ERR) begin
            r_error_n  = 1'b1;
            se0_seen_n = (sym == SYM_SE0);
        end
    end

endmodule

// File: tb/tb_usb_rx_phy_param.sv
// tb_usb_rx_phy_param
//   Bench for usb_rx_phy_param. Two instances: dut0 with default parameters
//   and dut1 with CLKS_PER_BIT=4, MAX_BYTES=2. A packet table drives
//   NRZI-encoded, bit-stuffed line symbols; expected bytes go into exp_q and
//   are compared against the bytes the monitor collects. Hand-written
//   sequences cover reset, input-to-rcving latency and reset mid-packet.
module tb_usb_rx_phy_param;

    localparam int CPB0 = 8;
    localparam int CPB1 = 4;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       dp0 = 1'b1, dm0 = 1'b0, dp1 = 1'b1, dm1 = 1'b0;
    logic [7:0] byte_data0, byte_data1;
    logic       byte_valid0, sop0, eop0, rcving0, r_error0;
    logic       byte_valid1, sop1, eop1, rcving1, r_error1;
    logic [6:0] byte_count0;
    logic [1:0] byte_count1;

    usb_rx_phy_param #(.CLKS_PER_BIT(CPB0), .MAX_BYTES(64), .STUFF_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .dp_i(dp0), .dm_i(dm0),
        .byte_data(byte_data0), .byte_valid(byte_valid0), .sop(sop0), .eop(eop0),
        .rcving(rcving0), .r_error(r_error0), .byte_count(byte_count0)
    );

    usb_rx_phy_param #(.CLKS_PER_BIT(CPB1), .MAX_BYTES(2), .STUFF_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .dp_i(dp1), .dm_i(dm1),
        .byte_data(byte_data1), .byte_valid(byte_valid1), .sop(sop1), .eop(eop1),
        .rcving(rcving1), .r_error(r_error1), .byte_count(byte_count1)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int sop_cnt[2];
    int eop_cnt[2];
    int bv_cnt[2];
    int checks = 0;
    int errors = 0;

    // Monitor: collects strobes away from the active edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            sop_cnt[i] = 0;
            eop_cnt[i] = 0;
            bv_cnt[i]  = 0;
        end
        forever begin
            @(negedge clk);
            if (byte_valid0) begin obs_q.push_back(byte_data0); bv_cnt[0]++; end
            if (byte_valid1) begin obs_q.push_back(byte_data1); bv_cnt[1]++; end
            if (sop0) sop_cnt[0]++;
            if (sop1) sop_cnt[1]++;
            if (eop0) eop_cnt[0]++;
            if (eop1) eop_cnt[1]++;
        end
    end

    task automatic check(input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", what, act, act, exp, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; holds the symbol for nbits bit times.
    task automatic drive_sym(input int inst, input logic [1:0] s, input int nbits);
        if (inst == 0) begin
            dp0 = s[1]; dm0 = s[0];
        end else begin
            dp1 = s[1]; dm1 = s[0];
        end
        repeat (nbits * ((inst == 0) ? CPB0 : CPB1)) @(negedge clk);
    endtask

    // Builds SYNC + data + extra bits, stuffs a bit after every six ones
    // (a one instead of the first stuffed zero when corrupt is set),
    // NRZI-encodes from J, then SE0 for two bits and J for four.
    task automatic send_pkt(input int inst, input logic [7:0] sync_b, input logic [31:0] data,
                            input int nbytes, input int extra, input bit corrupt);
        bit raw[$];
        bit enc[$];
        int ones;
        bit bad;
        logic [1:0] lvl;
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        for (int b = 0; b < nbytes; b++)
            for (int i = 0; i < 8; i++) raw.push_back(data[b*8+i]);
        for (int i = 0; i < extra; i++) raw.push_back(i[0]);
        ones = 0;
        bad  = corrupt;
        foreach (raw[k]) begin
            enc.push_back(raw[k]);
            ones = raw[k] ? ones + 1 : 0;
            if (ones == 6) begin
                enc.push_back(bad);
                bad  = 1'b0;
                ones = 0;
            end
        end
        lvl = J;
        foreach (enc[k]) begin
            if (!enc[k]) lvl = (lvl == J) ? K : J;
            drive_sym(inst, lvl, 1);
        end
        drive_sym(inst, SE0, 2);
        drive_sym(inst, J, 4);
    endtask

    // ---------------- packet table ----------------
    typedef struct {
        int          inst;
        logic [7:0]  sync_b;
        logic [31:0] data;
        int          nbytes;
        int          extra;
        bit          corrupt;
        int          exp_nvalid;
        int          exp_sop;
        int          exp_eop;
        int          exp_err;
        int          exp_count;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        vecs[0] = '{0, 8'h80, 32'h0000_3CA5, 2, 0, 1'b0, 2, 1, 1, 0, 2}; // two bytes
        vecs[1] = '{0, 8'h80, 32'h0000_00FF, 1, 0, 1'b0, 1, 1, 1, 0, 1}; // stuffed 0xFF
        vecs[2] = '{0, 8'h80, 32'h0000_00FF, 1, 0, 1'b1, 0, 1, 0, 1, 0}; // stuff error
        vecs[3] = '{0, 8'h80, 32'h0000_0055, 1, 4, 1'b0, 1, 1, 0, 1, 1}; // early EOP
        vecs[4] = '{0, 8'h81, 32'h0000_0000, 0, 0, 1'b0, 0, 0, 0, 1, 0}; // bad SYNC
        vecs[5] = '{0, 8'h80, 32'h0000_0000, 0, 0, 1'b0, 0, 1, 1, 0, 0}; // zero length
        vecs[6] = '{1, 8'h80, 32'h0033_2211, 3, 0, 1'b0, 2, 1, 0, 1, 2}; // overflow
        vecs[7] = '{0, 8'h80, 32'h0000_0000, 4, 0, 1'b0, 4, 1, 1, 0, 4}; // random
        vecs[8] = '{1, 8'h80, 32'h0000_5AC3, 2, 0, 1'b0, 2, 1, 1, 0, 2}; // exactly MAX
        vecs[7].data = $urandom();
        vecs[7].data[7:0] = 8'($urandom_range(8'hF0, 8'hFF)); // force a ones run

        // ---- reset: all outputs low for 20 cycles with an idle line ----
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("reset0_c%0d", c),
                  int'({byte_data0, byte_valid0, sop0, eop0, rcving0, r_error0, byte_count0}), 0);
            check($sformatf("reset1_c%0d", c),
                  int'({byte_data1, byte_valid1, sop1, eop1, rcving1, r_error1, byte_count1}), 0);
        end

        // ---- line change to rcving latency: three edges ----
        dp0 = K[1]; dm0 = K[0];
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check($sformatf("latency_edge%0d", e), int'(rcving0), (e == 3) ? 1 : 0);
        end
        @(negedge clk);
        repeat (CPB0) @(negedge clk);
        drive_sym(0, SE0, 2);
        drive_sym(0, J, 4);
        check("latency_recover_rcving", int'(rcving0), 0);
        obs_q.delete();

        // ---- table-driven packets ----
        for (int i = 0; i < NV; i++) begin
            int s0, e0, v0, in;
            int act_err, act_cnt, act_rcv;
            in = vecs[i].inst;
            for (int b = 0; b < vecs[i].exp_nvalid; b++)
                exp_q.push_back(vecs[i].data[b*8 +: 8]);
            s0 = sop_cnt[in];
            e0 = eop_cnt[in];
            v0 = bv_cnt[in];
            send_pkt(in, vecs[i].sync_b, vecs[i].data, vecs[i].nbytes,
                     vecs[i].extra, vecs[i].corrupt);
            while (exp_q.size() > 0) begin
                logic [7:0] exp_b;
                exp_b = exp_q.pop_front();
                if (obs_q.size() == 0) begin
                    check($sformatf("v%0d_missing_byte", i), -1, int'(exp_b));
                end else begin
                    check($sformatf("v%0d_byte", i), int'(obs_q.pop_front()), int'(exp_b));
                end
            end
            while (obs_q.size() > 0) begin
                check($sformatf("v%0d_extra_byte", i), int'(obs_q.pop_front()), -1);
            end
            if (in == 0) begin
                act_err = int'(r_error0); act_cnt = int'(byte_count0); act_rcv = int'(rcving0);
            end else begin
                act_err = int'(r_error1); act_cnt = int'(byte_count1); act_rcv = int'(rcving1);
            end
            check($sformatf("v%0d_valid_count", i), bv_cnt[in] - v0, vecs[i].exp_nvalid);
            check($sformatf("v%0d_sop", i), sop_cnt[in] - s0, vecs[i].exp_sop);
            check($sformatf("v%0d_eop", i), eop_cnt[in] - e0, vecs[i].exp_eop);
            check($sformatf("v%0d_r_error", i), act_err, vecs[i].exp_err);
            check($sformatf("v%0d_byte_count", i), act_cnt, vecs[i].exp_count);
            check($sformatf("v%0d_rcving", i), act_rcv, 0);
        end

        // ---- reset in the middle of a packet ----
        begin
            int e0;
            logic [1:0] sync_syms[8];
            sync_syms = '{K, J, K, J, K, J, K, K};
            e0 = eop_cnt[0];
            foreach (sync_syms[k]) drive_sym(0, sync_syms[k], 1);
            drive_sym(0, J, 1);
            drive_sym(0, K, 1);
            drive_sym(0, J, 1);
            check("midrst_rcving_before", int'(rcving0), 1);
            rst = 1'b1;
            dp0 = J[1]; dm0 = J[0];
            @(negedge clk);
            rst = 1'b0;
            check("midrst_outputs",
                  int'({byte_data0, byte_valid0, sop0, eop0, rcving0, r_error0, byte_count0}), 0);
            repeat (5 * CPB0) @(negedge clk);
            check("midrst_rcving_after", int'(rcving0), 0);
            check("midrst_r_error_after", int'(r_error0), 0);
            check("midrst_no_eop", eop_cnt[0] - e0, 0);
            check("midrst_no_bytes", obs_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog well inside the cycle budget.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
